pma_tx_link_sequencer: RTL and testbench

//  Sequences the TX datapath feeding the 8b/10b encoder and PMA serializer: link training, MAC data, idle and SKP insertion.

---
 rtl/pma_tx_seq_pkg.sv | 30 +++
 rtl/pma_tx_link_sequencer_if.sv | 21 ++
 rtl/pma_tx_skp_timer.sv | 32 +++
 rtl/pma_tx_link_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pma_tx_link_sequencer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pma_tx_seq_pkg.sv
// Shared types, symbol bytes and sizing helpers
// for the PMA TX link sequencer.
package pma_tx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRAIN  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_SKP    = 3'd3,
        ST_COMPL  = 3'd4
    } seq_state_e;

    localparam logic [7:0] SYM_COM   = 8'hBC;
    localparam logic [7:0] SYM_D10_2 = 8'h4A;
    localparam logic [7:0] SYM_SKP   = 8'h1C;
    localparam logic [7:0] SYM_IDL   = 8'h7C;
    localparam logic [7:0] SYM_D21_5 = 8'hB5;

    localparam logic K_CTRL = 1'b1;
    localparam logic K_DATA = 1'b0;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pma_tx_link_sequencer_if.sv
// MAC-side valid/ready byte handshake into
// the TX link sequencer.
interface pma_tx_link_sequencer_if;

    logic [7:0] Mac_Data;
    logic       Mac_Valid;
    logic       Mac_Ready;

    modport master (
        output Mac_Data,
        output Mac_Valid,
        input  Mac_Ready
    );

    modport slave (
        input  Mac_Data,
        input  Mac_Valid,
        output Mac_Ready
    );

endinterface

// File: rtl/pma_tx_skp_timer.sv
// Counts ACTIVE symbol slots and flags when a
// SKP ordered set is due.
module pma_tx_skp_timer
    import pma_tx_seq_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_skp_due
);

    localparam int W = cnt_w(SKP_INTERVAL);
    localparam logic [W-1:0] LAST = W'(SKP_INTERVAL - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_skp_due = (r_cnt == LAST);

endmodule

// File: rtl/pma_tx_link_sequencer.sv
// TX symbol sequencer: training, MAC data, idle and SKP insertion.
// Define TX_COMPLIANCE_EN to build in the compliance pattern state.
module pma_tx_link_sequencer
    import pma_tx_seq_pkg::*;
#(
    parameter int TS_COUNT     = 16,
    parameter int TS_LEN       = 16,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 4
) (
    input  logic                     Word_Rate_Clk,
    input  logic                     Rst,
    input  logic                     Tx_En,
    input  logic                     Train_Req,
    input  logic                     Compliance_Req,
    pma_tx_link_sequencer_if.slave   mac,
    output logic [7:0]               Tx_Symbol,
    output logic                     Tx_Symbol_K,
    output logic                     MAC_Data_En,
    output logic                     Link_Up,
    output logic [2:0]               Seq_State
);

    localparam int SYM_W = cnt_w(max2(TS_LEN, max2(SKP_LEN, 4)));
    localparam int SET_W = cnt_w(TS_COUNT);
    localparam logic [SYM_W-1:0] TS_LAST  = SYM_W'(TS_LEN - 1);
    localparam logic [SYM_W-1:0] SKP_LAST = SYM_W'(SKP_LEN - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(TS_COUNT - 1);

    seq_state_e       r_state;
    logic [SYM_W-1:0] r_sym_cnt;
    logic [SET_W-1:0] r_set_cnt;
    logic [7:0]       r_sym;
    logic             r_k;
    logic             r_en;
    logic             r_link;
    logic             w_skp_due;
    logic             w_ready;
    logic             w_tmr_en;
    logic             w_tmr_clr;

`ifndef TX_COMPLIANCE_EN
    logic w_unused_compl;
    assign w_unused_compl = Compliance_Req;
`endif

    assign w_tmr_en  = (r_state == ST_ACTIVE);
    assign w_tmr_clr = (r_state == ST_TRAIN) || (r_state == ST_SKP);

    pma_tx_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .i_clk     (Word_Rate_Clk),
        .i_rst     (Rst),
        .i_en      (w_tmr_en),
        .i_clr     (w_tmr_clr),
        .o_skp_due (w_skp_due)
    );

    // Refuse a byte on any slot that leaves ACTIVE so none is lost.
    assign w_ready = (r_state == ST_ACTIVE) && Tx_En
                     && !Train_Req && !w_skp_due;
    assign mac.Mac_Ready = w_ready;

    always_ff @(posedge Word_Rate_Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_sym_cnt <= '0;
            r_set_cnt <= '0;
            r_sym     <= 8'h00;
            r_k       <= 1'b0;
            r_en      <= 1'b0;
            r_link    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_sym  <= 8'h00;
                    r_k    <= K_DATA;
                    r_en   <= 1'b0;
                    r_link <= 1'b0;
                    if (Tx_En) begin
`ifdef TX_COMPLIANCE_EN
                        if (Compliance_Req) r_state <= ST_COMPL;
                        else
`endif
                        r_state <= ST_TRAIN;
                    end
                end
                ST_TRAIN: begin
                    r_en   <= 1'b1;
                    r_link <= 1'b0;
                    r_sym  <= (r_sym_cnt == '0) ? SYM_COM : SYM_D10_2;
                    r_k    <= (r_sym_cnt == '0) ? K_CTRL : K_DATA;
                    if (r_sym_cnt == TS_LAST) begin
                        r_sym_cnt <= '0;
                        if (!Tx_En) begin
                            r_set_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else if (r_set_cnt == SET_LAST) begin
                            r_set_cnt <= '0;
                            r_state   <= ST_ACTIVE;
                        end else begin
                            r_set_cnt <= r_set_cnt + SET_W'(1);
                        end
                    end else begin
                        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    r_en   <= 1'b1;
                    r_link <= 1'b1;
                    if (w_ready && mac.Mac_Valid) begin
                        r_sym <= mac.Mac_Data;
                        r_k   <= K_DATA;
                    end else begin
                        r_sym <= SYM_IDL;
                        r_k   <= K_CTRL;
                    end
                    if (!Tx_En)         r_state <= ST_IDLE;
                    else if (w_skp_due) r_state <= ST_SKP;
                    else if (Train_Req) r_state <= ST_TRAIN;
                end
                ST_SKP: begin
                    r_en   <= 1'b1;
                    r_link <= 1'b0;
                    r_k    <= K_CTRL;
                    r_sym  <= (r_sym_cnt == '0) ? SYM_COM : SYM_SKP;
                    if (r_sym_cnt == SKP_LAST) begin
                        r_sym_cnt <= '0;
                        if (!Tx_En)         r_state <= ST_IDLE;
                        else if (Train_Req) r_state <= ST_TRAIN;
                        else                r_state <= ST_ACTIVE;
                    end else begin
                        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                    end
                end
`ifdef TX_COMPLIANCE_EN
                ST_COMPL: begin
                    r_en   <= 1'b1;
                    r_link <= 1'b0;
                    unique case (r_sym_cnt[1:0])
                        2'd0: begin r_sym <= SYM_COM;   r_k <= K_CTRL; end
                        2'd1: begin r_sym <= SYM_D21_5; r_k <= K_DATA; end
                        2'd2: begin r_sym <= SYM_COM;   r_k <= K_CTRL; end
                        default: begin
                            r_sym <= SYM_D10_2;
                            r_k   <= K_DATA;
                        end
                    endcase
                    if (r_sym_cnt == SYM_W'(3)) begin
                        r_sym_cnt <= '0;
                        if (!Tx_En || !Compliance_Req) r_state <= ST_IDLE;
                    end else begin
                        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                    end
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_sym_cnt <= '0;
                    r_set_cnt <= '0;
                    r_sym     <= 8'h00;
                    r_k       <= 1'b0;
                    r_en      <= 1'b0;
                    r_link    <= 1'b0;
                end
            endcase
        end
    end

    assign Tx_Symbol   = r_sym;
    assign Tx_Symbol_K = r_k;
    assign MAC_Data_En = r_en;
    assign Link_Up     = r_link;
    assign Seq_State   = r_state;

endmodule

// File: tb/tb_pma_tx_link_sequencer.sv
// Directed bench for the TX link sequencer; run with SKP_INTERVAL=8.
// Define TX_COMPLIANCE_EN to exercise the compliance pattern.
module tb_pma_tx_link_sequencer;

    localparam int TS_COUNT = 16;
    localparam int TS_LEN   = 16;
    localparam int SKP_INT  = 8;
    localparam int SKP_LEN  = 4;

    logic       clk = 1'b0;
    logic       Rst;
    logic       Tx_En;
    logic       Train_Req;
    logic       Compliance_Req;
    logic [7:0] Tx_Symbol;
    logic       Tx_Symbol_K;
    logic       MAC_Data_En;
    logic       Link_Up;
    logic [2:0] Seq_State;

    int checks = 0;
    int errors = 0;

    pma_tx_link_sequencer_if mac();

    pma_tx_link_sequencer #(
        .TS_COUNT     (TS_COUNT),
        .TS_LEN       (TS_LEN),
        .SKP_INTERVAL (SKP_INT),
        .SKP_LEN      (SKP_LEN)
    ) dut (
        .Word_Rate_Clk  (clk),
        .Rst            (Rst),
        .Tx_En          (Tx_En),
        .Train_Req      (Train_Req),
        .Compliance_Req (Compliance_Req),
        .mac            (mac),
        .Tx_Symbol      (Tx_Symbol),
        .Tx_Symbol_K    (Tx_Symbol_K),
        .MAC_Data_En    (MAC_Data_En),
        .Link_Up        (Link_Up),
        .Seq_State      (Seq_State)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        Tx_En          = 1'b0;
        Train_Req      = 1'b0;
        Compliance_Req = 1'b0;
        mac.Mac_Valid  = 1'b0;
        mac.Mac_Data   = 8'h00;
    endtask

    // Reset, enable, and return on the first ACTIVE slot.
    task automatic bring_up;
        bit ok;
        ok = 1'b0;
        Rst = 1'b1;
        idle_inputs();
        step();
        Rst   = 1'b0;
        Tx_En = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (Seq_State == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL bring_up timeout state=%0d req=2", Seq_State);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (Tx_Symbol !== 8'h00 || Tx_Symbol_K !== 1'b0 ||
            MAC_Data_En !== 1'b0 || Link_Up !== 1'b0 ||
            Seq_State !== 3'd0 || mac.Mac_Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset sym=%h k=%b en=%b up=%b st=%0d rdy=%b req=0",
                     Tx_Symbol, Tx_Symbol_K, MAC_Data_En, Link_Up,
                     Seq_State, mac.Mac_Ready);
        end
        step();
        checks++;
        if (Seq_State !== 3'd0 || MAC_Data_En !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold st=%0d en=%b req=0/0",
                     Seq_State, MAC_Data_En);
        end
    endtask

    task automatic test_train;
        logic [7:0] exp;
        logic       ek;
        Rst = 1'b1;
        idle_inputs();
        step();
        Rst   = 1'b0;
        Tx_En = 1'b1;
        step();
        checks++;
        if (Seq_State !== 3'd1 || MAC_Data_En !== 1'b0) begin
            errors++;
            $display("FAIL train_entry st=%0d en=%b req=1/0",
                     Seq_State, MAC_Data_En);
        end
        for (int k = 0; k < TS_COUNT * TS_LEN; k++) begin
            step();
            exp = (k % TS_LEN == 0) ? 8'hBC : 8'h4A;
            ek  = (k % TS_LEN == 0);
            checks++;
            if (Tx_Symbol !== exp || Tx_Symbol_K !== ek ||
                MAC_Data_En !== 1'b1 || Link_Up !== 1'b0) begin
                errors++;
                $display("FAIL train_sym k=%0d sym=%h/%b en=%b up=%b req=%h/%b",
                         k, Tx_Symbol, Tx_Symbol_K, MAC_Data_En,
                         Link_Up, exp, ek);
            end
        end
        step();
        checks++;
        if (Link_Up !== 1'b1 || Tx_Symbol !== 8'h7C ||
            Tx_Symbol_K !== 1'b1 || mac.Mac_Ready !== 1'b1) begin
            errors++;
            $display("FAIL link_up up=%b sym=%h/%b rdy=%b req=1 7c/1 1",
                     Link_Up, Tx_Symbol, Tx_Symbol_K, mac.Mac_Ready);
        end
    endtask

    task automatic test_reset_mid_train;
        Rst = 1'b1;
        idle_inputs();
        step();
        Rst   = 1'b0;
        Tx_En = 1'b1;
        step();
        for (int k = 0; k < 37; k++) step();
        checks++;
        if (MAC_Data_En !== 1'b1 || Seq_State !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset en=%b st=%0d req=1/1",
                     MAC_Data_En, Seq_State);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (Tx_Symbol !== 8'h00 || MAC_Data_En !== 1'b0 ||
            Seq_State !== 3'd0 || Tx_Symbol_K !== 1'b0) begin
            errors++;
            $display("FAIL async_reset sym=%h en=%b st=%0d req=00/0/0",
                     Tx_Symbol, MAC_Data_En, Seq_State);
        end
        #1;
        Rst = 1'b0;
        step();
        checks++;
        if (Seq_State !== 3'd1) begin
            errors++;
            $display("FAIL retrain_state st=%0d req=1", Seq_State);
        end
        step();
        checks++;
        if (Tx_Symbol !== 8'hBC || Tx_Symbol_K !== 1'b1) begin
            errors++;
            $display("FAIL retrain_com sym=%h/%b req=bc/1",
                     Tx_Symbol, Tx_Symbol_K);
        end
        step();
        checks++;
        if (Tx_Symbol !== 8'h4A || Tx_Symbol_K !== 1'b0) begin
            errors++;
            $display("FAIL retrain_fill sym=%h/%b req=4a/0",
                     Tx_Symbol, Tx_Symbol_K);
        end
    endtask

    task automatic test_skp;
        logic [7:0] d;
        logic [7:0] es;
        bring_up();
        d = 8'h01;
        mac.Mac_Valid = 1'b1;
        mac.Mac_Data  = d;
        for (int i = 0; i < SKP_INT - 1; i++) begin
            #1;
            checks++;
            if (mac.Mac_Ready !== 1'b1) begin
                errors++;
                $display("FAIL skp_ready i=%0d rdy=%b req=1",
                         i, mac.Mac_Ready);
            end
            step();
            checks++;
            if (Tx_Symbol !== d || Tx_Symbol_K !== 1'b0) begin
                errors++;
                $display("FAIL skp_data i=%0d sym=%h/%b req=%h/0",
                         i, Tx_Symbol, Tx_Symbol_K, d);
            end
            d = d + 8'h01;
            mac.Mac_Data = d;
        end
        #1;
        checks++;
        if (mac.Mac_Ready !== 1'b0) begin
            errors++;
            $display("FAIL skp_due_ready rdy=%b req=0", mac.Mac_Ready);
        end
        step();
        checks++;
        if (Tx_Symbol !== 8'h7C || Tx_Symbol_K !== 1'b1 ||
            Seq_State !== 3'd3) begin
            errors++;
            $display("FAIL skp_due_slot sym=%h/%b st=%0d req=7c/1 3",
                     Tx_Symbol, Tx_Symbol_K, Seq_State);
        end
        for (int j = 0; j < SKP_LEN; j++) begin
            checks++;
            if (mac.Mac_Ready !== 1'b0) begin
                errors++;
                $display("FAIL skp_busy j=%0d rdy=%b req=0",
                         j, mac.Mac_Ready);
            end
            step();
            es = (j == 0) ? 8'hBC : 8'h1C;
            checks++;
            if (Tx_Symbol !== es || Tx_Symbol_K !== 1'b1) begin
                errors++;
                $display("FAIL skp_set j=%0d sym=%h/%b req=%h/1",
                         j, Tx_Symbol, Tx_Symbol_K, es);
            end
        end
        step();
        checks++;
        if (Tx_Symbol !== 8'h08 || Tx_Symbol_K !== 1'b0) begin
            errors++;
            $display("FAIL skp_resume sym=%h/%b req=08/0",
                     Tx_Symbol, Tx_Symbol_K);
        end
        mac.Mac_Valid = 1'b0;
    endtask

    task automatic test_traffic;
        int  nsend;
        int  nrecv;
        bit  acc;
        nsend = 0;
        nrecv = 0;
        acc   = 1'b0;
        bring_up();
        for (int cyc = 0; cyc < 400 && nrecv < 32; cyc++) begin
            if (acc) begin
                nsend++;
                mac.Mac_Valid = 1'b0;
            end
            if (cyc > 0 && MAC_Data_En && !Tx_Symbol_K) begin
                checks++;
                if (Tx_Symbol !== 8'(nrecv + 1)) begin
                    errors++;
                    $display("FAIL traffic_order sym=%h req=%h",
                             Tx_Symbol, 8'(nrecv + 1));
                end
                nrecv++;
            end else if (cyc > 0) begin
                checks++;
                if (Tx_Symbol !== 8'h7C && Tx_Symbol !== 8'hBC &&
                    Tx_Symbol !== 8'h1C) begin
                    errors++;
                    $display("FAIL traffic_ctrl sym=%h req=7c|bc|1c",
                             Tx_Symbol);
                end
            end
            if (!mac.Mac_Valid && nsend < 32 &&
                $urandom_range(0, 2) != 0) begin
                mac.Mac_Valid = 1'b1;
                mac.Mac_Data  = 8'(nsend + 1);
            end
            #1;
            acc = mac.Mac_Valid && mac.Mac_Ready;
            step();
        end
        checks++;
        if (nrecv != 32) begin
            errors++;
            $display("FAIL traffic_count got=%0d req=32", nrecv);
        end
        mac.Mac_Valid = 1'b0;
    endtask

    task automatic test_train_req_skp;
        bit found;
        logic [7:0] es;
        found = 1'b0;
        bring_up();
        for (int i = 0; i < 20; i++) begin
            if (Seq_State == 3'd3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL treq_wait_skp st=%0d req=3", Seq_State);
        end
        Train_Req = 1'b1;
        for (int j = 0; j < SKP_LEN; j++) begin
            step();
            es = (j == 0) ? 8'hBC : 8'h1C;
            checks++;
            if (Tx_Symbol !== es || Tx_Symbol_K !== 1'b1 ||
                Link_Up !== 1'b0) begin
                errors++;
                $display("FAIL treq_skp j=%0d sym=%h/%b up=%b req=%h/1 0",
                         j, Tx_Symbol, Tx_Symbol_K, Link_Up, es);
            end
        end
        checks++;
        if (Seq_State !== 3'd1) begin
            errors++;
            $display("FAIL treq_state st=%0d req=1", Seq_State);
        end
        step();
        checks++;
        if (Tx_Symbol !== 8'hBC || Tx_Symbol_K !== 1'b1 ||
            Link_Up !== 1'b0) begin
            errors++;
            $display("FAIL treq_ts sym=%h/%b up=%b req=bc/1 0",
                     Tx_Symbol, Tx_Symbol_K, Link_Up);
        end
        Train_Req = 1'b0;
    endtask

    task automatic test_txen_drop;
        bring_up();
        Tx_En = 1'b0;
        #1;
        checks++;
        if (mac.Mac_Ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready rdy=%b req=0", mac.Mac_Ready);
        end
        step();
        checks++;
        if (Seq_State !== 3'd0 || Tx_Symbol !== 8'h7C ||
            MAC_Data_En !== 1'b1) begin
            errors++;
            $display("FAIL drop_active st=%0d sym=%h en=%b req=0 7c 1",
                     Seq_State, Tx_Symbol, MAC_Data_En);
        end
        step();
        checks++;
        if (MAC_Data_En !== 1'b0 || Link_Up !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle en=%b up=%b req=0 0",
                     MAC_Data_En, Link_Up);
        end
        // Drop enable mid-set: the current TS must finish.
        Tx_En = 1'b1;
        step();
        for (int k = 0; k < 3; k++) step();
        Tx_En = 1'b0;
        for (int k = 0; k < 12; k++) step();
        checks++;
        if (Seq_State !== 3'd1 || Tx_Symbol !== 8'h4A) begin
            errors++;
            $display("FAIL drop_ts_mid st=%0d sym=%h req=1 4a",
                     Seq_State, Tx_Symbol);
        end
        step();
        checks++;
        if (Seq_State !== 3'd0 || Tx_Symbol !== 8'h4A ||
            MAC_Data_En !== 1'b1) begin
            errors++;
            $display("FAIL drop_ts_end st=%0d sym=%h en=%b req=0 4a 1",
                     Seq_State, Tx_Symbol, MAC_Data_En);
        end
    endtask

`ifdef TX_COMPLIANCE_EN
    task automatic test_compliance;
        logic [7:0] cp [4];
        logic [3:0] ck;
        cp = '{8'hBC, 8'hB5, 8'hBC, 8'h4A};
        ck = 4'b0101;
        Rst = 1'b1;
        idle_inputs();
        step();
        Rst            = 1'b0;
        Tx_En          = 1'b1;
        Compliance_Req = 1'b1;
        step();
        checks++;
        if (Seq_State !== 3'd4) begin
            errors++;
            $display("FAIL compl_entry st=%0d req=4", Seq_State);
        end
        for (int j = 0; j < 5; j++) begin
            step();
            checks++;
            if (Tx_Symbol !== cp[j % 4] || Tx_Symbol_K !== ck[j % 4] ||
                Link_Up !== 1'b0 || MAC_Data_En !== 1'b1) begin
                errors++;
                $display("FAIL compl_pat j=%0d sym=%h/%b up=%b req=%h/%b",
                         j, Tx_Symbol, Tx_Symbol_K, Link_Up,
                         cp[j % 4], ck[j % 4]);
            end
        end
        Compliance_Req = 1'b0;
        for (int j = 1; j < 4; j++) begin
            step();
            checks++;
            if (Tx_Symbol !== cp[j]) begin
                errors++;
                $display("FAIL compl_tail j=%0d sym=%h req=%h",
                         j, Tx_Symbol, cp[j]);
            end
        end
        checks++;
        if (Seq_State !== 3'd0) begin
            errors++;
            $display("FAIL compl_exit st=%0d req=0", Seq_State);
        end
        Tx_En = 1'b0;
        step();
        checks++;
        if (MAC_Data_En !== 1'b0) begin
            errors++;
            $display("FAIL compl_idle en=%b req=0", MAC_Data_En);
        end
    endtask
`else
    task automatic test_compliance;
        Rst = 1'b1;
        idle_inputs();
        step();
        Rst            = 1'b0;
        Tx_En          = 1'b1;
        Compliance_Req = 1'b1;
        step();
        checks++;
        if (Seq_State !== 3'd1) begin
            errors++;
            $display("FAIL compl_ignored st=%0d req=1", Seq_State);
        end
        step();
        checks++;
        if (Tx_Symbol !== 8'hBC || Tx_Symbol_K !== 1'b1) begin
            errors++;
            $display("FAIL compl_ignored_ts sym=%h/%b req=bc/1",
                     Tx_Symbol, Tx_Symbol_K);
        end
        Compliance_Req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_train();
        test_reset_mid_train();
        test_skp();
        test_traffic();
        test_train_req_skp();
        test_txen_drop();
        test_compliance();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
